// File: rtl/bmu_op_sequencer.sv
// Request front end for the BMU: buffers opcode requests, issues one decoded
// BMU operation at a time, captures the registered result and returns it by tag.
module bmu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_opcode,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             bmu_valid,
    output logic [31:0]      bmu_a,
    output logic [31:0]      bmu_b,
    output logic [22:0]      bmu_ap,
    input  logic [31:0]      bmu_result,
    input  logic             bmu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_error,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [15:0]      op_cnt,
    output logic [15:0]      err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = TAG_W + 1 + 23 + 64;
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Control word bit positions
    localparam int AP_ZBB    = 20;
    localparam int AP_LAND   = 16;
    localparam int AP_LXOR   = 15;
    localparam int AP_SLL    = 14;
    localparam int AP_SRA    = 13;
    localparam int AP_BEXT   = 11;
    localparam int AP_ADD    = 9;
    localparam int AP_SLT    = 8;
    localparam int AP_UNSIGN = 7;
    localparam int AP_SUB    = 6;
    localparam int AP_CLZ    = 5;
    localparam int AP_CPOP   = 4;
    localparam int AP_SEXTH  = 3;
    localparam int AP_MIN    = 2;
    localparam int AP_PACKU  = 1;
    localparam int AP_GORC   = 0;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    state_t             state_reg;
    logic [22:0]        dec_ap;
    logic               dec_legal;
    logic [31:0]        dec_b;
    logic [ENT_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]     count_reg, count_next;
    logic               full_reg;
    logic               fifo_empty, push, pop;
    logic [TAG_W-1:0]   head_tag;
    logic               head_legal;
    logic [22:0]        head_ap;
    logic [31:0]        head_a, head_b;
    logic [TAG_W-1:0]   work_tag_reg;
    logic               work_legal_reg;
    logic               bmu_valid_reg;
    logic [31:0]        bmu_a_reg, bmu_b_reg;
    logic [22:0]        bmu_ap_reg;
    logic               rsp_valid_reg, rsp_error_reg;
    logic [31:0]        rsp_result_reg;
    logic [TAG_W-1:0]   rsp_tag_reg;
    logic [15:0]        op_cnt_reg, err_cnt_reg;

    // Decoding at push time keeps the pop path a plain register load
    always_comb begin
        dec_ap    = '0;
        dec_legal = 1'b1;
        dec_b     = req_b;
        case (req_opcode)
            5'd0:  dec_ap[AP_ADD] = 1'b1;
            5'd1:  begin dec_ap[AP_LAND] = 1'b1; dec_ap[AP_ZBB] = 1'b1; end
            5'd2:  dec_ap[AP_LAND] = 1'b1;
            5'd3:  dec_ap[AP_LXOR] = 1'b1;
            5'd4:  dec_ap[AP_SLL] = 1'b1;
            5'd5:  dec_ap[AP_SRA] = 1'b1;
            5'd6:  dec_ap[AP_BEXT] = 1'b1;
            5'd7:  dec_ap[AP_SLT] = 1'b1;
            5'd8:  begin dec_ap[AP_SLT] = 1'b1; dec_ap[AP_UNSIGN] = 1'b1; end
            5'd9:  begin dec_ap[AP_MIN] = 1'b1; dec_ap[AP_SUB] = 1'b1; end
            5'd10: dec_ap[AP_CLZ] = 1'b1;
            5'd11: dec_ap[AP_CPOP] = 1'b1;
            5'd12: dec_ap[AP_SEXTH] = 1'b1;
            5'd13: dec_ap[AP_PACKU] = 1'b1;
            5'd14: begin dec_ap[AP_GORC] = 1'b1; dec_b = 32'h7; end
            default: dec_legal = 1'b0;
        endcase
    end

    assign req_ready  = ~full_reg;
    assign push       = req_valid && req_ready;
    assign fifo_empty = (count_reg == '0);
    assign pop        = !fifo_empty && ((state_reg == IDLE) || ((state_reg == RESP) && rsp_ready));
    assign {head_tag, head_legal, head_ap, head_a, head_b} = fifo_mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CNT_ONE;
        else if (!push && pop)
            count_next = count_reg - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {req_tag, dec_legal, dec_ap, req_a, dec_b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            work_tag_reg   <= '0;
            work_legal_reg <= 1'b0;
            bmu_valid_reg  <= 1'b0;
            bmu_a_reg      <= '0;
            bmu_b_reg      <= '0;
            bmu_ap_reg     <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_error_reg  <= 1'b0;
            rsp_tag_reg    <= '0;
            op_cnt_reg     <= '0;
            err_cnt_reg    <= '0;
        end else begin
            // BMU inputs are driven only for the single ISSUE cycle
            bmu_valid_reg <= 1'b0;
            bmu_a_reg     <= '0;
            bmu_b_reg     <= '0;
            bmu_ap_reg    <= '0;
            if (pop) begin
                work_tag_reg   <= head_tag;
                work_legal_reg <= head_legal;
                if (head_legal) begin
                    bmu_valid_reg <= 1'b1;
                    bmu_a_reg     <= head_a;
                    bmu_b_reg     <= head_b;
                    bmu_ap_reg    <= head_ap;
                end
            end
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty)
                        state_reg <= ISSUE;
                end
                ISSUE: begin
                    if (work_legal_reg) begin
                        op_cnt_reg <= op_cnt_reg + 16'd1;
                        state_reg  <= CAPT;
                    end else begin
                        rsp_result_reg <= '0;
                        rsp_error_reg  <= 1'b1;
                        rsp_tag_reg    <= work_tag_reg;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= RESP;
                    end
                end
                CAPT: begin
                    rsp_result_reg <= bmu_result;
                    rsp_error_reg  <= bmu_error;
                    rsp_tag_reg    <= work_tag_reg;
                    rsp_valid_reg  <= 1'b1;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        if (rsp_error_reg && (err_cnt_reg != 16'hFFFF))
                            err_cnt_reg <= err_cnt_reg + 16'd1;
                        state_reg <= fifo_empty ? IDLE : ISSUE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bmu_valid  = bmu_valid_reg;
    assign bmu_a      = bmu_a_reg;
    assign bmu_b      = bmu_b_reg;
    assign bmu_ap     = bmu_ap_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_error  = rsp_error_reg;
    assign rsp_tag    = rsp_tag_reg;
    assign op_cnt     = op_cnt_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_bmu_op_sequencer.sv
// Self-checking bench for bmu_op_sequencer with a behavioural BMU stub and a
// queue-based reference of expected issues and responses.
module tb_bmu_op_sequencer;

    localparam int TAG_W = 4;

    logic             clk, rst;
    logic             req_valid, req_ready;
    logic [4:0]       req_opcode;
    logic [31:0]      req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic             bmu_valid;
    logic [31:0]      bmu_a, bmu_b;
    logic [22:0]      bmu_ap;
    logic [31:0]      bmu_result;
    logic             bmu_error;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_error;
    logic [TAG_W-1:0] rsp_tag;
    logic [15:0]      op_cnt, err_cnt;

    bmu_op_sequencer #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .bmu_valid(bmu_valid), .bmu_a(bmu_a), .bmu_b(bmu_b), .bmu_ap(bmu_ap),
        .bmu_result(bmu_result), .bmu_error(bmu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .rsp_tag(rsp_tag),
        .op_cnt(op_cnt), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [22:0] ap; logic [31:0] a; logic [31:0] b; } issue_t;
    typedef struct { logic [31:0] result; logic error; logic [TAG_W-1:0] tag; } rsp_t;

    issue_t exp_issue[$];
    rsp_t   exp_rsp[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    logic [15:0] model_op  = 16'd0;
    logic [15:0] model_err = 16'd0;
    logic        rnd_ready = 1'b0;

    // Monitor state
    logic             prev_bv = 1'b0;
    logic             hold = 1'b0;
    logic [31:0]      hold_result;
    logic             hold_error;
    logic [TAG_W-1:0] hold_tag;
    logic [31:0]      last_result = '0;
    logic             last_error = 1'b0;
    logic [TAG_W-1:0] last_tag = '0;
    logic [22:0]      last_ap = '0;
    logic [31:0]      last_b = '0;
    issue_t           mon_i;
    rsp_t             mon_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Control word required for each legal opcode
    function automatic logic [22:0] exp_ap(input int op);
        case (op)
            0:  return 23'h000200;
            1:  return 23'h110000;
            2:  return 23'h010000;
            3:  return 23'h008000;
            4:  return 23'h004000;
            5:  return 23'h002000;
            6:  return 23'h000800;
            7:  return 23'h000100;
            8:  return 23'h000180;
            9:  return 23'h000044;
            10: return 23'h000020;
            11: return 23'h000010;
            12: return 23'h000008;
            13: return 23'h000002;
            14: return 23'h000001;
            default: return 23'h0;
        endcase
    endfunction

    function automatic int ap_to_op(input logic [22:0] ap);
        for (int k = 0; k < 15; k++)
            if (exp_ap(k) === ap) return k;
        return -1;
    endfunction

    // Architectural meaning of each operation
    function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'hDEADBEEF;
        case (op)
            0:  r = a + b;
            1:  r = a & ~b;
            2:  r = a & b;
            3:  r = a ^ b;
            4:  r = a << b[4:0];
            5:  r = 32'($signed(a) >>> b[4:0]);
            6:  r = (a >> b[4:0]) & 32'h1;
            7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8:  r = (a < b) ? 32'd1 : 32'd0;
            9:  r = ($signed(a) < $signed(b)) ? a : b;
            10: begin r = 0; for (int k = 31; k >= 0 && !a[k]; k--) r = r + 1; end
            11: r = $countones(a);
            12: r = {{16{a[15]}}, a[15:0]};
            13: r = {b[31:16], a[31:16]};
            14: for (int k = 0; k < 4; k++) r[k*8 +: 8] = (a[k*8 +: 8] != 0) ? 8'hFF : 8'h00;
            default: r = 32'hDEADBEEF;
        endcase
        return r;
    endfunction

    // Behavioural BMU: result_ff registered one cycle after valid_in
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bmu_result <= '0;
            bmu_error  <= 1'b0;
        end else if (bmu_valid) begin
            bmu_result <= ref_op(ap_to_op(bmu_ap), bmu_a, bmu_b);
            bmu_error  <= (ap_to_op(bmu_ap) < 0);
        end
    end

    task automatic note_accept(input int op, input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] tag);
        issue_t i;
        rsp_t   r;
        if (op < 15) begin
            i.ap = exp_ap(op); i.a = a; i.b = (op == 14) ? 32'h7 : b;
            exp_issue.push_back(i);
            r.result = ref_op(op, a, b); r.error = 1'b0;
            model_op = model_op + 16'd1;
        end else begin
            r.result = '0; r.error = 1'b1;
        end
        r.tag = tag;
        exp_rsp.push_back(r);
    endtask

    task automatic send(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        logic acc;
        acc = 1'b0;
        req_valid = 1'b1; req_opcode = op[4:0]; req_a = a; req_b = b; req_tag = tag;
        for (int i = 0; i < 60 && !acc; i++) begin
            acc = req_ready;
            if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("send_accept", {31'b0, acc}, 32'd1);
        if (acc) note_accept(op, a, b, tag);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_rsp.size() == 0 && !rsp_valid) break;
            @(posedge clk); #1;
        end
        chk("drain_rsp_queue", exp_rsp.size(), 32'd0);
        chk("drain_issue_queue", exp_issue.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_bv = 1'b0;
            hold    = 1'b0;
        end else begin
            if (bmu_valid) begin
                chk("bmu_valid_one_cycle", {31'b0, prev_bv}, 32'd0);
                if (exp_issue.size() == 0) begin
                    chk("unexpected_issue", {31'b0, bmu_valid}, 32'd0);
                end else begin
                    mon_i = exp_issue.pop_front();
                    chk("issue_ap", {9'b0, bmu_ap}, {9'b0, mon_i.ap});
                    chk("issue_a", bmu_a, mon_i.a);
                    chk("issue_b", bmu_b, mon_i.b);
                    last_ap = bmu_ap;
                    last_b  = bmu_b;
                end
            end else begin
                chk("bmu_idle_zero", bmu_a | bmu_b | {9'b0, bmu_ap}, 32'd0);
            end
            prev_bv = bmu_valid;
            if (hold) begin
                chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
                chk("hold_result", rsp_result, hold_result);
                chk("hold_meta", {27'b0, rsp_error, rsp_tag}, {27'b0, hold_error, hold_tag});
            end
            if (rsp_valid && rsp_ready) begin
                hold = 1'b0;
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    chk("rsp_result", rsp_result, mon_r.result);
                    chk("rsp_error", {31'b0, rsp_error}, {31'b0, mon_r.error});
                    chk("rsp_tag", {28'b0, rsp_tag}, {28'b0, mon_r.tag});
                    $display("rsp tag=%0d result=%h error=%0d", rsp_tag, rsp_result, rsp_error);
                    if (mon_r.error && model_err != 16'hFFFF) model_err = model_err + 16'd1;
                    last_result = rsp_result;
                    last_error  = rsp_error;
                    last_tag    = rsp_tag;
                end
            end else if (rsp_valid) begin
                hold = 1'b1;
                hold_result = rsp_result;
                hold_error  = rsp_error;
                hold_tag    = rsp_tag;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int op;
        rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0;
        req_tag = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_bmu_valid", {31'b0, bmu_valid}, 32'd0);
        chk("reset_counters", {op_cnt, err_cnt}, 32'd0);
        chk("reset_rsp_data", rsp_result | {27'b0, rsp_error, rsp_tag}, 32'd0);

        // ADD latency: issue in cycle 1, response in cycle 3
        send(0, 32'd7, 32'd5, 4'd3);
        @(posedge clk); #1;
        chk("lat_c1_bmu_valid", {31'b0, bmu_valid}, 32'd1);
        chk("lat_c1_ap", {9'b0, bmu_ap}, 32'h000200);
        @(posedge clk); #1;
        chk("lat_c2_bmu_valid", {31'b0, bmu_valid}, 32'd0);
        chk("lat_c2_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_c3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("lat_c3_result", rsp_result, 32'd12);
        chk("lat_c3_tag", {28'b0, rsp_tag}, 32'd3);
        drain();
        chk("add_op_cnt", {16'b0, op_cnt}, 32'd1);

        // ORCB forces operand B
        send(14, 32'h00100200, 32'h12345678, 4'd1);
        drain();
        chk("orcb_ap", {9'b0, last_ap}, 32'h000001);
        chk("orcb_b", last_b, 32'h7);
        chk("orcb_result", last_result, 32'h00FFFF00);

        send(8, 32'hFFFFFFFF, 32'd1, 4'd2);
        drain();
        chk("sltu_ap", {9'b0, last_ap}, 32'h000180);
        chk("sltu_result", last_result, 32'd0);
        send(7, 32'hFFFFFFFF, 32'd1, 4'd2);
        drain();
        chk("slt_ap", {9'b0, last_ap}, 32'h000100);
        chk("slt_result", last_result, 32'd1);

        // Illegal opcode
        send(20, 32'h1234, 32'h5678, 4'd9);
        drain();
        chk("illegal_result", last_result, 32'd0);
        chk("illegal_meta", {27'b0, last_error, last_tag}, {27'b0, 1'b1, 4'd9});
        chk("illegal_err_cnt", {16'b0, err_cnt}, 32'd1);
        chk("illegal_op_cnt", {16'b0, op_cnt}, 32'd4);

        // Back-pressure: six back-to-back pushes with rsp_ready low
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            logic acc;
            logic [31:0] a, b;
            op = $urandom_range(0, 14);
            a = $urandom; b = $urandom;
            req_valid = 1'b1; req_opcode = op[4:0]; req_a = a; req_b = b; req_tag = i[3:0];
            acc = req_ready;
            @(posedge clk); #1;
            if (acc) begin
                note_accept(op, a, b, i[3:0]);
                n_acc++;
            end
        end
        req_valid = 1'b0;
        chk("bp_accepted", n_acc, 32'd5);
        chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        repeat (4) @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();

        // Randomised traffic with random response back-pressure
        rnd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 31) : $urandom_range(0, 14);
            send(op, $urandom, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        rnd_ready = 1'b0;
        rsp_ready = 1'b1;
        drain();
        chk("rand_op_cnt", {16'b0, op_cnt}, {16'b0, model_op});
        chk("rand_err_cnt", {16'b0, err_cnt}, {16'b0, model_err});

        // Reset during CAPT with two requests queued
        send(0, 32'd10, 32'd20, 4'd1);
        send(3, 32'd10, 32'd20, 4'd2);
        send(2, 32'd10, 32'd20, 4'd3);
        rst = 1'b1;
        #1;
        exp_issue.delete();
        exp_rsp.delete();
        model_op = 16'd0;
        model_err = 16'd0;
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_valids", {30'b0, bmu_valid, rsp_valid}, 32'd0);
        chk("mid_rst_bmu", bmu_a | bmu_b | {9'b0, bmu_ap}, 32'd0);
        chk("mid_rst_rsp", rsp_result | {27'b0, rsp_error, rsp_tag}, 32'd0);
        chk("mid_rst_counters", {op_cnt, err_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", {30'b0, bmu_valid, rsp_valid}, 32'd0);
        end
        send(0, 32'd1, 32'd1, 4'd5);
        drain();
        chk("post_rst_add", last_result, 32'd2);
        chk("post_rst_tag", {28'b0, last_tag}, 32'd5);
        chk("post_rst_op_cnt", {16'b0, op_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
